// File: rtl/inverter_pkg.sv
// Shared definitions for the inverter gate path.
//   bridge_mode_t      : requested / applied H-bridge mode (codes 5-7 illegal)
//   bridge_seq_state_t : bridge_sequencer FSM states
//   gate_pat_t         : {top, bot} gate drive pair, bit0 = gate 1
//   mode_to_gates()    : mode -> gate pattern lookup
//   mode_is_legal()    : raw 3-bit code legality check
package inverter_pkg;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_PLUS    = 3'd1,
    MODE_MINUS   = 3'd2,
    MODE_PAUSE_P = 3'd3,
    MODE_PAUSE_N = 3'd4
  } bridge_mode_t;

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_BREAK  = 2'd1,
    ST_FAULT  = 2'd2
  } bridge_seq_state_t;

  typedef struct packed {
    logic [3:0] top;
    logic [3:0] bot;
  } gate_pat_t;

  localparam gate_pat_t GATES_OFF     = '{top: 4'b0000, bot: 4'b0000};
  localparam gate_pat_t GATES_PLUS    = '{top: 4'b0001, bot: 4'b0010};
  localparam gate_pat_t GATES_MINUS   = '{top: 4'b0010, bot: 4'b0001};
  localparam gate_pat_t GATES_PAUSE_P = '{top: 4'b0100, bot: 4'b1000};
  localparam gate_pat_t GATES_PAUSE_N = '{top: 4'b1000, bot: 4'b0100};

  function automatic gate_pat_t mode_to_gates(input bridge_mode_t mode);
    gate_pat_t g;
    case (mode)
      MODE_PLUS:    g = GATES_PLUS;
      MODE_MINUS:   g = GATES_MINUS;
      MODE_PAUSE_P: g = GATES_PAUSE_P;
      MODE_PAUSE_N: g = GATES_PAUSE_N;
      default:      g = GATES_OFF;
    endcase
    return g;
  endfunction

  function automatic logic mode_is_legal(input logic [2:0] code);
    return (code <= 3'd4);
  endfunction

endpackage

// File: rtl/bridge_sequencer_hold_counter.sv
// Loadable saturating down-counter used for dead time and minimum on-time.
//   clk, rstn   : clock, asynchronous active-low reset
//   load_i      : load load_val_i this cycle (has priority over counting)
//   load_val_i  : value to load
//   zero_o      : counter currently equals zero
// The counter stops at zero instead of wrapping.
module hold_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bridge_sequencer.sv
// H-bridge gate sequencer with break-before-make dead time, minimum on-time
// and latched fault shutdown.
//   clk, rstn     : clock, asynchronous active-low reset
//   req_valid     : mode request valid
//   req_mode      : requested mode code (bridge_mode_t, 5-7 illegal)
//   req_ready     : request accepted on req_valid && req_ready at posedge
//   fault         : level fault input, sampled every cycle
//   fault_clr     : single-cycle clear of the latched fault
//   o_top, o_bot  : registered gate drives, bit0 = gate 1
//   cur_mode      : mode currently driven on the gates (OFF in break/fault)
//   fault_latched : sticky fault indication
//   err_illegal   : one-cycle pulse for an accepted illegal mode code
module bridge_sequencer
  import inverter_pkg::*;
#(
  parameter int FREQ         = 50_000_000,
  parameter int DEADTIME_CYC = FREQ / 500_000,   // 2 us
  parameter int MIN_ON_CYC   = FREQ / 100_000,   // 10 us
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic [2:0] req_mode,
  output logic       req_ready,
  input  logic       fault,
  input  logic       fault_clr,
  output logic [3:0] o_top,
  output logic [3:0] o_bot,
  output logic [2:0] cur_mode,
  output logic       fault_latched,
  output logic       err_illegal
);

  // Entering ST_BREAK loads one less than the dead time because the gates are
  // already off during the cycle in which the break state is entered.
  localparam logic [CNT_W-1:0] DEAD_LD  = CNT_W'(DEADTIME_CYC);
  localparam logic [CNT_W-1:0] BREAK_LD = CNT_W'(DEADTIME_CYC - 1);
  localparam logic [CNT_W-1:0] MINON_LD = CNT_W'(MIN_ON_CYC);

  bridge_seq_state_t state_q, state_d;
  bridge_mode_t      cur_q, cur_d;
  bridge_mode_t      tgt_q, tgt_d;
  gate_pat_t         gates_q, gates_d;
  logic              latched_q, latched_d;
  logic              err_q, err_d;

  logic              hold_ld;
  logic [CNT_W-1:0]  hold_val;
  logic              hold_zero;
  logic              req_legal;
  logic              accept;
  bridge_mode_t      req_tgt;

  hold_counter #(.CNT_W(CNT_W)) u_hold (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (hold_ld),
    .load_val_i (hold_val),
    .zero_o     (hold_zero)
  );

  assign req_ready = (state_q == ST_STABLE) && hold_zero && !fault && !latched_q;
  assign accept    = req_valid && req_ready;
  assign req_legal = mode_is_legal(req_mode);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    gates_d   = gates_q;
    latched_d = latched_q;
    err_d     = 1'b0;
    hold_ld   = 1'b0;
    hold_val  = '0;
    req_tgt   = req_legal ? bridge_mode_t'(req_mode) : MODE_OFF;

    if (fault) begin
      // Fault wins over everything, including a pending break target.
      state_d   = ST_FAULT;
      cur_d     = MODE_OFF;
      tgt_d     = MODE_OFF;
      gates_d   = GATES_OFF;
      latched_d = 1'b1;
    end else begin
      case (state_q)
        ST_STABLE: begin
          if (accept) begin
            err_d = !req_legal;
            if (req_tgt == cur_q) begin
              // Same mode: keep gates and hold untouched so nothing glitches.
            end else if (req_tgt == MODE_OFF) begin
              cur_d    = MODE_OFF;
              gates_d  = GATES_OFF;
              hold_ld  = 1'b1;
              hold_val = DEAD_LD;
            end else if (cur_q == MODE_OFF) begin
              cur_d    = req_tgt;
              gates_d  = mode_to_gates(req_tgt);
              hold_ld  = 1'b1;
              hold_val = MINON_LD;
            end else begin
              state_d  = ST_BREAK;
              cur_d    = MODE_OFF;
              tgt_d    = req_tgt;
              gates_d  = GATES_OFF;
              hold_ld  = 1'b1;
              hold_val = BREAK_LD;
            end
          end
        end
        ST_BREAK: begin
          if (hold_zero) begin
            state_d  = ST_STABLE;
            cur_d    = tgt_q;
            gates_d  = mode_to_gates(tgt_q);
            tgt_d    = MODE_OFF;
            hold_ld  = 1'b1;
            hold_val = MINON_LD;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state_d   = ST_STABLE;
            cur_d     = MODE_OFF;
            gates_d   = GATES_OFF;
            latched_d = 1'b0;
            hold_ld   = 1'b1;
            hold_val  = DEAD_LD;
          end
        end
        default: begin
          state_d = ST_STABLE;
          cur_d   = MODE_OFF;
          gates_d = GATES_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_STABLE;
      cur_q     <= MODE_OFF;
      tgt_q     <= MODE_OFF;
      gates_q   <= GATES_OFF;
      latched_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      gates_q   <= gates_d;
      latched_q <= latched_d;
      err_q     <= err_d;
    end
  end

  assign o_top         = gates_q.top;
  assign o_bot         = gates_q.bot;
  assign cur_mode      = cur_q;
  assign fault_latched = latched_q;
  assign err_illegal   = err_q;

endmodule

// File: tb/tb_bridge_sequencer.sv
module tb_bridge_sequencer;

  localparam int DT = 100;
  localparam int MO = 500;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_mode = 3'd0;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic       req_ready;
  logic [3:0] o_top;
  logic [3:0] o_bot;
  logic [2:0] cur_mode;
  logic       fault_latched;
  logic       err_illegal;

  always #5 clk = ~clk;

  bridge_sequencer #(
    .FREQ         (50_000_000),
    .DEADTIME_CYC (DT),
    .MIN_ON_CYC   (MO),
    .CNT_W        (16)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_mode      (req_mode),
    .req_ready     (req_ready),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .o_top         (o_top),
    .o_bot         (o_bot),
    .cur_mode      (cur_mode),
    .fault_latched (fault_latched),
    .err_illegal   (err_illegal)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent {top,bot} table for each mode code.
  function automatic logic [7:0] pat(input logic [2:0] m);
    case (m)
      3'd1:    return 8'b0001_0010;
      3'd2:    return 8'b0010_0001;
      3'd3:    return 8'b0100_1000;
      3'd4:    return 8'b1000_0100;
      default: return 8'b0000_0000;
    endcase
  endfunction

  typedef struct {
    int         due;
    logic [7:0] g;
    logic [2:0] m;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t push_e;

  // Expect gates = pattern(m) and cur_mode = m, d edges after the drive point.
  task automatic expect_at(input int d, input logic [2:0] m, input string tag);
    push_e.due = cyc + d;
    push_e.g   = pat(m);
    push_e.m   = m;
    push_e.tag = tag;
    sb.push_back(push_e);
  endtask

  // Output monitor: scoreboard pops plus safety invariants.
  logic [7:0] prev_g, last_act, g_now;
  int zero_run, on_cnt;

  always @(posedge clk) begin
    #2;
    if (!rstn) begin
      prev_g   = 8'h00;
      last_act = 8'h00;
      zero_run = 0;
      on_cnt   = 0;
    end else begin
      g_now = {o_top, o_bot};
      chk("shoot_through", {28'd0, o_top & o_bot}, 32'd0);
      if (g_now != prev_g && g_now != 8'h00) begin
        chk("direct_switch_prev", {24'd0, prev_g}, 32'd0);
        if (last_act != 8'h00 && last_act != g_now)
          chk("dead_time_ok", {31'd0, (zero_run >= DT)}, 32'd1);
        on_cnt = 0;
      end
      if (g_now == 8'h00) begin
        zero_run++;
      end else begin
        zero_run = 0;
        last_act = g_now;
        on_cnt++;
      end
      if (g_now != 8'h00 && on_cnt <= MO)
        chk("ready_in_min_on", {31'd0, req_ready}, 32'd0);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        if (mon_e.due < cyc) begin
          chk({mon_e.tag, "_late"}, cyc, mon_e.due);
        end else begin
          chk({mon_e.tag, "_gates"}, {24'd0, g_now}, {24'd0, mon_e.g});
          chk({mon_e.tag, "_mode"}, {29'd0, cur_mode}, {29'd0, mon_e.m});
        end
      end
      prev_g = g_now;
    end
  end

  task automatic start_req(input logic [2:0] m);
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = m;
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic finish_req(output logic err_seen);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    err_seen  = err_illegal;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic e;
    int   n;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_top", {28'd0, o_top}, 32'd0);
    chk("rst_bot", {28'd0, o_bot}, 32'd0);
    chk("rst_mode", {29'd0, cur_mode}, 32'd0);
    chk("rst_latched", {31'd0, fault_latched}, 32'd0);
    chk("rst_err", {31'd0, err_illegal}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // PLUS from OFF: pattern next cycle, held for MO cycles
    start_req(3'd1);
    expect_at(1, 3'd1, "plus_on");
    expect_at(MO, 3'd1, "plus_hold");
    finish_req(e);
    chk("plus_no_err", {31'd0, e}, 32'd0);
    wait_ready(n);
    chk("plus_min_on", n, MO);

    // PLUS while PLUS: no glitch, hold stays at zero
    start_req(3'd1);
    expect_at(1, 3'd1, "same_1");
    expect_at(2, 3'd1, "same_2");
    expect_at(4, 3'd1, "same_4");
    finish_req(e);
    chk("same_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);

    // Illegal code 6 while PLUS: treated as OFF, one-cycle error pulse
    start_req(3'd6);
    expect_at(1, 3'd0, "illegal_off");
    finish_req(e);
    chk("illegal_err_pulse", {31'd0, e}, 32'd1);
    @(negedge clk);
    chk("illegal_err_one_cycle", {31'd0, err_illegal}, 32'd0);
    wait_ready(n);
    chk("illegal_off_hold", n, DT - 1);

    // PAUSE_P from OFF
    start_req(3'd3);
    expect_at(1, 3'd3, "pausep_on");
    finish_req(e);
    wait_ready(n);
    chk("pausep_min_on", n, MO);

    // MINUS from PAUSE_P: exactly DT zero cycles then MINUS
    start_req(3'd2);
    expect_at(1, 3'd0, "break_start");
    expect_at(DT, 3'd0, "break_last");
    expect_at(DT + 1, 3'd2, "minus_on");
    finish_req(e);
    wait_ready(n);
    chk("break_plus_min_on", n, DT + MO);

    // Fault during a break
    start_req(3'd4);
    expect_at(1, 3'd0, "break2_start");
    finish_req(e);
    repeat (20) @(negedge clk);
    fault = 1'b1;
    @(negedge clk);
    chk("fault_gates", {24'd0, o_top, o_bot}, 32'd0);
    chk("fault_mode", {29'd0, cur_mode}, 32'd0);
    chk("fault_latched_set", {31'd0, fault_latched}, 32'd1);
    chk("fault_ready", {31'd0, req_ready}, 32'd0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr_ignored_in_fault", {31'd0, fault_latched}, 32'd1);
    repeat (150) @(negedge clk);
    chk("target_discarded", {24'd0, o_top, o_bot}, 32'd0);
    fault = 1'b0;
    repeat (3) @(negedge clk);
    chk("fault_sticky", {31'd0, fault_latched}, 32'd1);
    chk("sticky_ready", {31'd0, req_ready}, 32'd0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr_latched", {31'd0, fault_latched}, 32'd0);
    chk("clr_mode", {29'd0, cur_mode}, 32'd0);
    wait_ready(n);
    chk("clr_dead_hold", n, DT);

    // Fault and request in the same cycle: request refused
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = 3'd1;
    fault     = 1'b1;
    #1;
    chk("ready_low_on_fault", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    fault     = 1'b0;
    chk("prio_latched", {31'd0, fault_latched}, 32'd1);
    chk("prio_gates", {24'd0, o_top, o_bot}, 32'd0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    wait_ready(n);
    chk("prio_clr_hold", n, DT);
    chk("prio_not_accepted", {29'd0, cur_mode}, 32'd0);

    // Asynchronous reset in the middle of a break
    start_req(3'd2);
    expect_at(1, 3'd2, "minus2_on");
    finish_req(e);
    wait_ready(n);
    chk("minus2_min_on", n, MO);
    start_req(3'd1);
    expect_at(1, 3'd0, "break3_start");
    finish_req(e);
    repeat (10) @(negedge clk);
    chk("mid_break_ready", {31'd0, req_ready}, 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_break_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_break_gates", {24'd0, o_top, o_bot}, 32'd0);
    chk("arst_break_mode", {29'd0, cur_mode}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Asynchronous reset while the fault is latched
    @(negedge clk);
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    chk("pre_arst_latched", {31'd0, fault_latched}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_fault_latched", {31'd0, fault_latched}, 32'd0);
    chk("arst_fault_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    // Randomised traffic; invariants are checked by the monitor
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_mode  = 3'($urandom_range(0, 7));
      if (fault) fault = ($urandom_range(0, 3) != 0);
      else       fault = ($urandom_range(0, 999) == 0);
      fault_clr = (!fault && $urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    fault     = 1'b0;
    fault_clr = 1'b0;
    repeat (5) @(negedge clk);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
